// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared types and constants for the register-hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Register address width of the architectural register file.
  localparam int RAW_W = 5;

  // Register 0 reads as zero and never carries a dependency.
  localparam logic [RAW_W-1:0] REG_ZERO = '0;

  // Forward-select encodings seen by the EX-stage operand muxes.
  localparam int FWD_REGFILE = 0;
  localparam int FWD_EXMEM   = 1;
  localparam int FWD_MEMWB   = 2;

  // One in-flight register write: valid, destination, produced by a load.
  typedef struct packed {
    logic             v;
    logic [RAW_W-1:0] rd;
    logic             ld;
  } inflight_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID-stage request bundle and scoreboard response bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int RAW    = 5,
  parameter int FSEL_W = 2,
  parameter int CNT_W  = 32
);

  logic              id_valid;
  logic [RAW-1:0]    id_rs;
  logic              id_rs_used;
  logic [RAW-1:0]    id_rt;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [RAW-1:0]    id_rd;
  logic              id_is_load;
  logic              id_flush;

  logic              stall;
  logic              issue;
  logic [FSEL_W-1:0] fwd_rs;
  logic [FSEL_W-1:0] fwd_rt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  issue_cnt;

  // ID stage side: presents the decoded instruction, consumes the verdict.
  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_rd, id_is_load, id_flush,
    input  stall, issue, fwd_rs, fwd_rt, stall_cnt, issue_cnt
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_rd, id_is_load, id_flush,
    output stall, issue, fwd_rs, fwd_rt, stall_cnt, issue_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_age_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_age_pipe
// Brief    : WB_LAT-deep shift register of in-flight writes; index = age.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_age_pipe
  import hazard_scoreboard_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  inflight_t               entry_i,
  output inflight_t [WB_LAT-1:0]  pipe_o
);

  inflight_t [WB_LAT-1:0] pipe_q;
  inflight_t [WB_LAT-1:0] pipe_d;

  // Every entry ages by one stage per cycle; the new entry lands at age 0.
  always_comb begin
    pipe_d = {pipe_q[WB_LAT-2:0], entry_i};
  end

  // Pipe register with asynchronous clear to all-bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pipe_o = pipe_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Register-hazard scoreboard beside ID: stall / forward select per
//            source operand, plus stall and issue performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int WB_LAT = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32,
  parameter int FSEL_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  hazard_scoreboard_if.slave  bus
);

  inflight_t [WB_LAT-1:0] pipe;
  inflight_t              entry;
  logic                   rs_hz;
  logic                   rt_hz;
  logic [FSEL_W-1:0]      rs_fwd;
  logic [FSEL_W-1:0]      rt_fwd;
  logic                   stall;
  logic                   issue;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic [CNT_W-1:0]       issue_cnt_q;

  // Resolve one source operand against the pipe: {hazard, forward select}.
  // Scanning from oldest to youngest lets the youngest match win. The WB
  // entry is written to the register file in time for ID, so a youngest
  // match there needs neither a stall nor a forward.
  function automatic logic [FSEL_W:0] resolve(
    input logic [RAW-1:0]         src,
    input logic                   used,
    input inflight_t [WB_LAT-1:0] p
  );
    logic              found;
    logic              ld;
    int                age;
    logic              hz;
    logic [FSEL_W-1:0] f;
    found = 1'b0;
    ld    = 1'b0;
    age   = 0;
    hz    = 1'b0;
    f     = FSEL_W'(FWD_REGFILE);
    for (int a = WB_LAT - 1; a >= 0; a--) begin
      if (p[a].v && (p[a].rd == src)) begin
        found = 1'b1;
        age   = a;
        ld    = p[a].ld;
      end
    end
    if (used && (src != REG_ZERO) && (int'(src) < NREG) &&
        found && (age < WB_LAT - 1)) begin
      if (FWD_EN != 0) begin
        // A load result exists only after MEM: one bubble, then forward.
        if ((age == 0) && ld) begin
          hz = 1'b1;
        end else begin
          f = FSEL_W'(age + 1);
        end
      end else begin
        hz = 1'b1;
      end
    end
    return {hz, f};
  endfunction

  // Per-operand hazard and forward resolution.
  always_comb begin
    {rs_hz, rs_fwd} = resolve(bus.id_rs, bus.id_rs_used, pipe);
    {rt_hz, rt_fwd} = resolve(bus.id_rt, bus.id_rt_used, pipe);
  end

  // Flush wins over stall; forwarding is only meaningful for an issuing op.
  always_comb begin
    stall = bus.id_valid & ~bus.id_flush & (rs_hz | rt_hz);
    issue = bus.id_valid & ~stall & ~bus.id_flush;
    entry.v  = issue & bus.id_wr_en & (bus.id_rd != REG_ZERO);
    entry.rd = bus.id_rd;
    entry.ld = bus.id_is_load;
  end

  hazard_scoreboard_age_pipe #(
    .WB_LAT (WB_LAT)
  ) u_age_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .entry_i (entry),
    .pipe_o  (pipe)
  );

  // Free-running performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
      issue_cnt_q <= issue_cnt_q + CNT_W'(issue);
    end
  end

  assign bus.stall     = stall;
  assign bus.issue     = issue;
  assign bus.fwd_rs    = (bus.id_valid & ~stall) ? rs_fwd : '0;
  assign bus.fwd_rt    = (bus.id_valid & ~stall) ? rt_fwd : '0;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.issue_cnt = issue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed scoreboard bench for hazard_scoreboard, with one
//            forwarding and one non-forwarding instance on shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic       we;
    logic [4:0] rd;
    logic       ld;
    logic       fl;
  } instr_t;

  typedef struct {
    int          sel;
    string       tag;
    logic        stall;
    logic        issue;
    logic [1:0]  frs;
    logic [1:0]  frt;
    bit          chk;
    logic [31:0] scnt;
    logic [31:0] icnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RAW(5), .FSEL_W(2), .CNT_W(32)) bus1 ();
  hazard_scoreboard_if #(.RAW(5), .FSEL_W(2), .CNT_W(32)) bus0 ();

  hazard_scoreboard #(
    .NREG(32), .RAW(5), .WB_LAT(3), .FWD_EN(1), .CNT_W(32), .FSEL_W(2)
  ) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1)
  );

  hazard_scoreboard #(
    .NREG(32), .RAW(5), .WB_LAT(3), .FWD_EN(0), .CNT_W(32), .FSEL_W(2)
  ) dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0)
  );

  function automatic instr_t NOP();
    return '0;
  endfunction

  function automatic instr_t RT(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{v:1'b1, rs:rs, rsu:1'b1, rt:rt, rtu:1'b1, we:1'b1, rd:rd, ld:1'b0, fl:1'b0};
  endfunction

  function automatic instr_t ADDI(input logic [4:0] rt, input logic [4:0] rs);
    return '{v:1'b1, rs:rs, rsu:1'b1, rt:rt, rtu:1'b0, we:1'b1, rd:rt, ld:1'b0, fl:1'b0};
  endfunction

  function automatic instr_t LW(input logic [4:0] rt, input logic [4:0] base);
    return '{v:1'b1, rs:base, rsu:1'b1, rt:rt, rtu:1'b0, we:1'b1, rd:rt, ld:1'b1, fl:1'b0};
  endfunction

  function automatic instr_t FLUSHED(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{v:1'b1, rs:rs, rsu:1'b1, rt:rt, rtu:1'b1, we:1'b1, rd:rd, ld:1'b0, fl:1'b1};
  endfunction

  task automatic apply(input instr_t in);
    bus1.id_valid = in.v;  bus1.id_rs = in.rs; bus1.id_rs_used = in.rsu;
    bus1.id_rt = in.rt;    bus1.id_rt_used = in.rtu; bus1.id_wr_en = in.we;
    bus1.id_rd = in.rd;    bus1.id_is_load = in.ld;  bus1.id_flush = in.fl;
    bus0.id_valid = in.v;  bus0.id_rs = in.rs; bus0.id_rs_used = in.rsu;
    bus0.id_rt = in.rt;    bus0.id_rt_used = in.rtu; bus0.id_wr_en = in.we;
    bus0.id_rd = in.rd;    bus0.id_is_load = in.ld;  bus0.id_flush = in.fl;
  endtask

  // One ID cycle: drive after the edge, queue what the monitor must see.
  task automatic cyc(input int sel, input string tag, input instr_t in, input logic rstn,
                     input logic es, input logic ei, input logic [1:0] efs, input logic [1:0] eft,
                     input bit chk = 1'b0, input logic [31:0] sc = '0, input logic [31:0] ic = '0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn;
    apply(in);
    e.sel = sel; e.tag = tag; e.stall = es; e.issue = ei; e.frs = efs; e.frt = eft;
    e.chk = chk; e.scnt = sc; e.icnt = ic;
    q.push_back(e);
  endtask

  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) cyc(sel, "idle", NOP(), 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic cnt(input int sel, input string tag, input logic [31:0] sc, input logic [31:0] ic);
    cyc(sel, tag, NOP(), 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, sc, ic);
  endtask

  // Monitor: outputs are combinational, so every queued cycle is compared
  // at the falling edge of the cycle it was driven in.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic        a_st, a_is;
      logic [1:0]  a_fs, a_ft;
      logic [31:0] a_sc, a_ic;
      bit          bad;
      e = q.pop_front();
      if (e.sel == 1) begin
        a_st = bus1.stall; a_is = bus1.issue; a_fs = bus1.fwd_rs; a_ft = bus1.fwd_rt;
        a_sc = bus1.stall_cnt; a_ic = bus1.issue_cnt;
      end else begin
        a_st = bus0.stall; a_is = bus0.issue; a_fs = bus0.fwd_rs; a_ft = bus0.fwd_rt;
        a_sc = bus0.stall_cnt; a_ic = bus0.issue_cnt;
      end
      vectors++;
      bad = (a_st !== e.stall) || (a_is !== e.issue) || (a_fs !== e.frs) || (a_ft !== e.frt);
      if (e.chk && ((a_sc !== e.scnt) || (a_ic !== e.icnt))) bad = 1'b1;
      if (bad) begin
        miscompares++;
        $display("FAIL %s (fwd_en=%0d): got stall=%b issue=%b fwd_rs=%0d fwd_rt=%0d scnt=%0d icnt=%0d, want stall=%b issue=%b fwd_rs=%0d fwd_rt=%0d scnt=%0d icnt=%0d%s",
                 e.tag, e.sel, a_st, a_is, a_fs, a_ft, a_sc, a_ic,
                 e.stall, e.issue, e.frs, e.frt, e.scnt, e.icnt, e.chk ? "" : " (counters not checked)");
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    apply(NOP());

    // Reset state.
    cyc(1, "reset", NOP(), 1'b0, 0, 0, 2'd0, 2'd0, 1'b1, 0, 0);

    // Back-to-back dependency forwards from EX/MEM.
    cyc(1, "t1_add", RT(3, 1, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t1_sub", RT(4, 3, 1), 1'b1, 0, 1, 2'd1, 2'd0);
    idle(1, 3);

    // One gap forwards from MEM/WB; two gaps read the register file.
    cyc(1, "t2_add", RT(3, 1, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t2_nop", NOP(), 1'b1, 0, 0, 2'd0, 2'd0);
    cyc(1, "t2_and_gap1", RT(5, 3, 3), 1'b1, 0, 1, 2'd2, 2'd2);
    idle(1, 3);
    cyc(1, "t2_add_b", RT(3, 1, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    idle(1, 2);
    cyc(1, "t2_and_gap2", RT(5, 3, 3), 1'b1, 0, 1, 2'd0, 2'd0);
    idle(1, 3);

    // Youngest producer wins.
    cyc(1, "pri_add1", RT(3, 1, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "pri_add2", RT(3, 4, 5), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "pri_use", RT(6, 3, 0), 1'b1, 0, 1, 2'd1, 2'd0);
    idle(1, 3);

    // Load-use: one stall, then MEM/WB forward on both operands.
    cyc(1, "t3_reset", NOP(), 1'b0, 0, 0, 2'd0, 2'd0, 1'b1, 0, 0);
    cyc(1, "t3_lw", LW(9, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t3_add_stall", RT(10, 9, 9), 1'b1, 1, 0, 2'd0, 2'd0);
    cyc(1, "t3_add_fwd", RT(10, 9, 9), 1'b1, 0, 1, 2'd2, 2'd2);
    cnt(1, "t3_counters", 1, 2);
    idle(1, 2);

    // $0 never hazards; a flush beats a pending hazard and leaves no entry.
    cyc(1, "t4_addi_r0", ADDI(0, 1), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t4_use_r0", RT(3, 0, 0), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t4_lw", LW(9, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t4_flush", FLUSHED(7, 9, 9), 1'b1, 0, 0, 2'd0, 2'd0);
    cyc(1, "t4_after_flush", RT(8, 7, 9), 1'b1, 0, 1, 2'd0, 2'd2);
    cnt(1, "t4_counters", 1, 6);
    idle(1, 2);

    // No forwarding paths: stall until the producer reaches WB.
    cyc(0, "t5_reset", NOP(), 1'b0, 0, 0, 2'd0, 2'd0, 1'b1, 0, 0);
    cyc(0, "t5_add", RT(3, 1, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(0, "t5_sub_stall1", RT(4, 3, 1), 1'b1, 1, 0, 2'd0, 2'd0);
    cyc(0, "t5_sub_stall2", RT(4, 3, 1), 1'b1, 1, 0, 2'd0, 2'd0);
    cyc(0, "t5_sub_issue", RT(4, 3, 1), 1'b1, 0, 1, 2'd0, 2'd0);
    cnt(0, "t5_counters", 2, 2);
    idle(0, 3);

    // Reset while a load sits at age 0 and its consumer is in ID.
    cyc(1, "t6_lw", LW(9, 2), 1'b1, 0, 1, 2'd0, 2'd0);
    cyc(1, "t6_rst_mid", RT(10, 9, 9), 1'b0, 0, 1, 2'd0, 2'd0, 1'b1, 0, 0);
    cyc(1, "t6_after_rst", RT(10, 9, 9), 1'b1, 0, 1, 2'd0, 2'd0);
    cnt(1, "t6_counters", 0, 1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
